// File: rtl/sipo_deframe8_pkg.sv
// Shared types and sizing for the sipo_deframe8 serial receive stage.
package sipo_deframe8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_e;

    localparam int N_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = $clog2(N_DEFAULT + 1);

endpackage

// File: rtl/sipo_deframe8_if.sv
// Bit-stream input and valid/ready word output bundle of sipo_deframe8.
interface sipo_deframe8_if
    import sipo_deframe8_pkg::*;
#(
    parameter int N = N_DEFAULT
);

    logic         en;
    logic         sync;
    logic         si;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         ovr;
    logic         ovr_clr;
    logic         par_err;

    modport master (
        output en, sync, si, dout_ready, ovr_clr,
        input  dout, dout_valid, ovr, par_err
    );

    modport slave (
        input  en, sync, si, dout_ready, ovr_clr,
        output dout, dout_valid, ovr, par_err
    );

endinterface

// File: rtl/sipo_deframe8_shift.sv
// N-bit MSB-first left shift register with first-bit load and running parity.
module sipo_shift #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         si_i,
    output logic [N-1:0] q_o,
    output logic         par_o
);

    logic [N-1:0] q_q;
    logic         par_q;

    // clr starts a fresh word: the incoming bit becomes the only bit held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= '0;
            par_q <= 1'b0;
        end else if (en_i) begin
            if (clr_i) begin
                q_q   <= {{(N-1){1'b0}}, si_i};
                par_q <= si_i;
            end else begin
                q_q   <= {q_q[N-2:0], si_i};
                par_q <= par_q ^ si_i;
            end
        end
    end

    assign q_o   = q_q;
    assign par_o = par_q;

endmodule

// File: rtl/sipo_deframe8.sv
// Serial-to-parallel deframer with valid/ready output and sticky overrun.
// Optional trailing even-parity bit when SIPO_DEFRAME_PARITY_EN is defined.
module sipo_deframe8
    import sipo_deframe8_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    sipo_deframe8_if.slave bus
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     dout_q;
    logic             valid_q;
    logic             ovr_q;
    logic             perr_q;

    logic [N-1:0]     sh_q;
    logic             sh_par;
    logic             shift_en;
    logic             word_done;
    logic             handshake;
    logic [N-1:0]     word_d;
    logic             par_err_d;

    assign handshake = valid_q & bus.dout_ready;
    // The parity bit itself is never shifted in; it is only XORed at completion.
    assign shift_en  = bus.en & (bus.sync | (state_q == ST_DATA));

`ifdef SIPO_DEFRAME_PARITY_EN
    assign word_done = bus.en & ~bus.sync & (state_q == ST_PAR);
    assign word_d    = sh_q;
    assign par_err_d = sh_par ^ bus.si;
`else
    assign word_done = bus.en & ~bus.sync & (state_q == ST_DATA) & (cnt_q == LAST);
    assign word_d    = {sh_q[N-2:0], bus.si};
    assign par_err_d = 1'b0;
    wire   par_unused = sh_par;
`endif

    sipo_shift #(.N(N)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .en_i  (shift_en),
        .clr_i (bus.sync),
        .si_i  (bus.si),
        .q_o   (sh_q),
        .par_o (sh_par)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            if (bus.en) begin
                if (bus.sync) begin
                    state_q <= ST_DATA;
                    cnt_q   <= CNT_W'(1);
                end else begin
                    case (state_q)
                        ST_DATA: begin
                            if (cnt_q == LAST) begin
                                cnt_q <= '0;
`ifdef SIPO_DEFRAME_PARITY_EN
                                state_q <= ST_PAR;
`else
                                state_q <= ST_IDLE;
`endif
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        ST_PAR: begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end
                        default: ;
                    endcase
                end
            end

            // A word may land in the same cycle the previous one is consumed.
            if (word_done && (!valid_q || handshake)) begin
                dout_q  <= word_d;
                valid_q <= 1'b1;
                perr_q  <= par_err_d;
            end else if (handshake) begin
                valid_q <= 1'b0;
            end

            if (word_done && valid_q && !handshake) begin
                ovr_q <= 1'b1;
            end else if (bus.ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.ovr        = ovr_q;
    assign bus.par_err    = perr_q;

endmodule

// File: tb/tb_sipo_deframe8.sv
// Directed bench for sipo_deframe8; frames carry a parity bit when SIPO_DEFRAME_PARITY_EN is defined.
module tb_sipo_deframe8;

`ifdef SIPO_DEFRAME_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sipo_deframe8_if #(.N(8)) bus ();

    sipo_deframe8 #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic s, input logic b);
        bus.en   = 1'b1;
        bus.sync = s;
        bus.si   = b;
        @(posedge clk);
        #1;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        bus.si   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Everything but the final bit of a frame (final = LSB, or parity bit).
    task automatic send_head(input logic [7:0] w, input bit gap);
        strobe(1'b1, w[7]);
        for (int i = 6; i >= 1; i--) begin
            if (gap) idle(1);
            strobe(1'b0, w[i]);
        end
        if (PAR != 0) begin
            if (gap) idle(1);
            strobe(1'b0, w[0]);
        end
    endtask

    task automatic send_last(input logic [7:0] w, input bit gap);
        if (gap) idle(1);
        if (PAR != 0) strobe(1'b0, ^w);
        else          strobe(1'b0, w[0]);
    endtask

    task automatic send_word(input logic [7:0] w, input bit gap);
        send_head(w, gap);
        send_last(w, gap);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.en = 1'b0; bus.sync = 1'b0; bus.si = 1'b0;
        bus.dout_ready = 1'b0; bus.ovr_clr = 1'b0;
        idle(2);
        checks++;
        if (bus.dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        checks++;
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid); end
        checks++;
        if (bus.ovr !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", bus.ovr); end
        checks++;
        if (bus.par_err !== 1'b0) begin failures++; $display("FAIL reset_par_err got=%b exp=0", bus.par_err); end
        @(negedge clk);
        rst = 1'b1;
        // Unsynced bits in IDLE must be ignored.
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b1);
        idle(1);
    endtask

    task automatic test_basic;
        bus.dout_ready = 1'b1;
        send_head(8'hA5, 1'b0);
        checks++;
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", bus.dout_valid); end
        send_last(8'hA5, 1'b0);
        checks++;
        if (bus.dout !== 8'hA5) begin failures++; $display("FAIL basic_dout got=%h exp=a5", bus.dout); end
        checks++;
        if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.dout_valid); end
        checks++;
        if (bus.ovr !== 1'b0) begin failures++; $display("FAIL basic_ovr got=%b exp=0", bus.ovr); end
        checks++;
        if (bus.par_err !== 1'b0) begin failures++; $display("FAIL basic_par_err got=%b exp=0", bus.par_err); end
        idle(1);
        checks++;
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", bus.dout_valid); end
        checks++;
        if (bus.dout !== 8'hA5) begin failures++; $display("FAIL basic_dout_hold got=%h exp=a5", bus.dout); end
    endtask

    task automatic test_gapped;
        bus.dout_ready = 1'b1;
        send_word(8'h3C, 1'b1);
        checks++;
        if (bus.dout !== 8'h3C) begin failures++; $display("FAIL gapped_dout got=%h exp=3c", bus.dout); end
        checks++;
        if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL gapped_valid got=%b exp=1", bus.dout_valid); end
        idle(1);
    endtask

    task automatic test_overrun;
        bus.dout_ready = 1'b0;
        send_word(8'h11, 1'b0);
        checks++;
        if (bus.dout !== 8'h11) begin failures++; $display("FAIL ovr_first_dout got=%h exp=11", bus.dout); end
        send_word(8'h22, 1'b0);
        checks++;
        if (bus.dout !== 8'h11) begin failures++; $display("FAIL ovr_dout_kept got=%h exp=11", bus.dout); end
        checks++;
        if (bus.ovr !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", bus.ovr); end
        checks++;
        if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", bus.dout_valid); end
        bus.ovr_clr = 1'b1;
        idle(1);
        bus.ovr_clr = 1'b0;
        checks++;
        if (bus.ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", bus.ovr); end
        checks++;
        if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_held got=%b exp=1", bus.dout_valid); end
        bus.dout_ready = 1'b1;
        idle(1);
        bus.dout_ready = 1'b0;
        checks++;
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%b exp=0", bus.dout_valid); end
    endtask

    task automatic test_back_to_back;
        bus.dout_ready = 1'b0;
        send_word(8'h11, 1'b0);
        send_head(8'h22, 1'b0);
        bus.dout_ready = 1'b1;
        send_last(8'h22, 1'b0);
        bus.dout_ready = 1'b0;
        checks++;
        if (bus.dout !== 8'h22) begin failures++; $display("FAIL b2b_dout got=%h exp=22", bus.dout); end
        checks++;
        if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", bus.dout_valid); end
        checks++;
        if (bus.ovr !== 1'b0) begin failures++; $display("FAIL b2b_ovr got=%b exp=0", bus.ovr); end
        bus.dout_ready = 1'b1;
        idle(1);
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_ovr_dominant;
        bus.dout_ready = 1'b0;
        send_word(8'h5A, 1'b0);
        send_head(8'h69, 1'b0);
        bus.ovr_clr = 1'b1;
        send_last(8'h69, 1'b0);
        bus.ovr_clr = 1'b0;
        checks++;
        if (bus.ovr !== 1'b1) begin failures++; $display("FAIL ovr_dominant got=%b exp=1", bus.ovr); end
        checks++;
        if (bus.dout !== 8'h5A) begin failures++; $display("FAIL ovr_dom_dout got=%h exp=5a", bus.dout); end
        bus.ovr_clr = 1'b1;
        bus.dout_ready = 1'b1;
        idle(1);
        bus.ovr_clr = 1'b0;
        bus.dout_ready = 1'b0;
    endtask

    task automatic test_resync;
        bus.dout_ready = 1'b1;
        strobe(1'b1, 1'b1);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b1);
        send_head(8'hF0, 1'b0);
        checks++;
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL resync_partial_out got=%b exp=0", bus.dout_valid); end
        send_last(8'hF0, 1'b0);
        checks++;
        if (bus.dout !== 8'hF0) begin failures++; $display("FAIL resync_dout got=%h exp=f0", bus.dout); end
        checks++;
        if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL resync_valid got=%b exp=1", bus.dout_valid); end
        idle(1);
    endtask

    task automatic test_reset_midframe;
        bus.dout_ready = 1'b0;
        send_word(8'h55, 1'b0);
        send_word(8'h66, 1'b0);
        strobe(1'b1, 1'b1);
        strobe(1'b0, 1'b1);
        strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.dout !== 8'h00) begin failures++; $display("FAIL rstmid_dout got=%h exp=00", bus.dout); end
        checks++;
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", bus.dout_valid); end
        checks++;
        if (bus.ovr !== 1'b0) begin failures++; $display("FAIL rstmid_ovr got=%b exp=0", bus.ovr); end
        @(negedge clk);
        rst = 1'b1;
        bus.dout_ready = 1'b1;
        send_word(8'h81, 1'b0);
        checks++;
        if (bus.dout !== 8'h81) begin failures++; $display("FAIL rstmid_after_dout got=%h exp=81", bus.dout); end
        checks++;
        if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL rstmid_after_valid got=%b exp=1", bus.dout_valid); end
        idle(1);
    endtask

`ifdef SIPO_DEFRAME_PARITY_EN
    task automatic test_parity;
        bus.dout_ready = 1'b1;
        send_head(8'hA5, 1'b0);
        checks++;
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL par_early_valid got=%b exp=0", bus.dout_valid); end
        strobe(1'b0, 1'b1);
        checks++;
        if (bus.par_err !== 1'b1) begin failures++; $display("FAIL par_err_bad got=%b exp=1", bus.par_err); end
        checks++;
        if (bus.dout !== 8'hA5) begin failures++; $display("FAIL par_dout got=%h exp=a5", bus.dout); end
        idle(1);
        bus.dout_ready = 1'b0;
        send_head(8'hA5, 1'b0);
        strobe(1'b0, 1'b0);
        checks++;
        if (bus.par_err !== 1'b0) begin failures++; $display("FAIL par_err_good got=%b exp=0", bus.par_err); end
        // Dropped word with bad parity must leave par_err untouched.
        send_head(8'h01, 1'b0);
        strobe(1'b0, 1'b0);
        checks++;
        if (bus.par_err !== 1'b0) begin failures++; $display("FAIL par_dropped got=%b exp=0", bus.par_err); end
        checks++;
        if (bus.ovr !== 1'b1) begin failures++; $display("FAIL par_ovr got=%b exp=1", bus.ovr); end
        bus.ovr_clr = 1'b1;
        bus.dout_ready = 1'b1;
        idle(1);
        bus.ovr_clr = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_overrun();
        test_back_to_back();
        test_ovr_dominant();
        test_resync();
        test_reset_midframe();
`ifdef SIPO_DEFRAME_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_deframe8.md
# sipo_deframe8

Serial-to-parallel receive stage consuming the `SO` bit stream of the 8-bit left-shift register (MSB first). It frames incoming bits into N-bit words and presents them on a registered output with a valid/ready handshake. A second word can be received while the previous one waits for the consumer. Overrun is reported with a sticky flag.

## Interface
- `N`, 8: data word width; must be at least 2.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: bit strobe; `si` is sampled only on edges where `en`=1.
- `sync`, input, 1: qualified by `en`; marks the current `si` bit as bit 0 (MSB) of a new word.
- `si`, input, 1: serial data, connected to the upstream `SO`.
- `dout`, output, N: received word, MSB = first bit received.
- `dout_valid`, output, 1: `dout` holds an unconsumed word.
- `dout_ready`, input, 1: consumer accepts `dout` when `dout_valid` and `dout_ready` are both 1.
- `ovr`, output, 1: sticky overrun flag.
- `ovr_clr`, input, 1: synchronous clear of `ovr`.
- `par_err`, output, 1: parity error for the word currently in `dout`.

## Operation
- **Reset values:** state=IDLE, `dout`=0, `dout_valid`=0, `ovr`=0, `par_err`=0, bit counter=0, shift register=0.
- **FSM states:** IDLE, DATA, PAR (PAR exists only with the macro).
- **IDLE:**
  - `en`=1 and `sync`=1: shift in `si`, set count=1, go to DATA.
  - `en`=1 and `sync`=0: bit is ignored.
- **DATA:**
  - Each `en` shifts left with `si` entering at the LSB, and count increments.
  - When count reaches N: go to PAR if enabled; otherwise complete the word and return to IDLE.
- **Mid-frame sync:** `en`=1 with `sync`=1 in DATA or PAR discards the partial word, treats `si` as the new bit 0, sets count=1, and enters DATA. `ovr` and `dout` are unaffected.
- **Word completion:**
  - If `dout_valid`=0, or a handshake occurs in the same cycle: load `dout` from the shift register, set `dout_valid`=1, and update `par_err`.
  - Otherwise: drop the new word, keep `dout` unchanged, and set `ovr`=1.
- **Handshake:** a handshake with no completion in the same cycle clears `dout_valid`. `dout` keeps its old value after being consumed.
- **`ovr`:** set-dominant. If a set and `ovr_clr` coincide, `ovr` stays 1.
- **`en`=0:** state, counter and shift register hold; the handshake still operates.

## Timing
- **Latency:** `dout_valid` rises on the same edge that samples the last bit (the Nth data bit, or the parity bit with the macro). It is visible in the following cycle.
- **Throughput:** back-to-back strobes every cycle are supported, giving one word per N cycles (N+1 with parity).
- The consumer may hold `dout_ready` low indefinitely; the stage keeps receiving into the shift register.
- `dout`, `dout_valid`, `ovr` and `par_err` are registered outputs with no combinational path from inputs.
- **Reset mid-frame:** all state returns to reset values immediately (asynchronously); the partial word is lost.

## Configuration
- **`SIPO_DEFRAME_PARITY_EN` defined:**
  - One extra bit follows the N data bits and is handled in state PAR.
  - Even parity over data plus parity bit.
  - `par_err` = 1 if the XOR of all N+1 bits is 1; it is loaded together with `dout`.
  - A dropped (overrun) word does not update `par_err`.
- **Undefined:** there is no PAR state and `par_err` is tied to 0. The port list is identical in both builds.

## Structure
- **Shared package / include:**
  - State encodings: IDLE=2'd0, DATA=2'd1, PAR=2'd2.
  - Default `N`.
  - Counter width constant `$clog2(N+1)`.
- **One sub-module, `sipo_shift`:** N-bit left shift register with `en`, a `clr` load-first-bit path, and running parity. The FSM, counter, output register, handshake and overrun logic live in the top level.

## Test plan
- **Basic word:** `dout_ready`=1, sync plus bits 1,0,1,0,0,1,0,1 on consecutive strobes → `dout`=0xA5, `dout_valid` high for 1 cycle, `ovr`=0.
- **Gapped strobes:** `en` toggled every other cycle, word 0x3C → `dout`=0x3C after the 8th strobe; no extra shifting during gaps.
- **Overrun:**
  - Setup: `dout_ready`=0; send 0x11, then 0x22.
  - Expected: `dout`=0x11, `ovr`=1.
  - Then `ovr_clr`=1 → `ovr`=0.
  - Then `dout_ready`=1 for one cycle → `dout_valid`=0.
- **Simultaneous drain and completion:** last bit of 0x22 coincides with a handshake on 0x11 → `dout`=0x22, `dout_valid`=1, `ovr`=0.
- **Resync:** 3 bits, then a new sync with word 0xF0 → `dout`=0xF0; the partial word is never output.
- **Reset mid-frame:** `rst`=0 after 4 bits → all outputs 0 immediately. After release, a full word 0x81 → `dout`=0x81.
- **Parity build:** with the macro, 0xA5 followed by parity bit 1 → `par_err`=1; with parity bit 0 → `par_err`=0.
